// File: rtl/npc_pkg.sv
// Shared definitions for the NPC multi-cycle core: sequencer state encodings
// and reset constants.
package npc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_MDU_WAIT   = 3'd5,
    ST_WB         = 3'd6,
    ST_HALT       = 3'd7
  } state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h00000013;
  localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/npc_wait_timer.sv
// Response-wait timer: counts cycles while enabled, clears when told, and
// flags the last allowed cycle of a wait.
module npc_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] wait_cnt;

  assign expired = (wait_cnt == W'(TIMEOUT - 1));

  // Saturates at the compare value; the sequencer leaves the wait state then.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= '0;
    end else if (en && !expired) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch into an instruction register, then
// execute / memory / mul-div wait / writeback, with perf counters and halt.
//
// Handshakes: a request transfers on the rising edge where valid && ready;
// valid is held until then. Responses are single-cycle pulses that only count
// in the wait state expecting them; anywhere else they are ignored.
module exec_sequencer
  import npc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_data,
  output logic [31:0]      instr,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_muldiv,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_we,
  output logic             rf_we_gate,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state
);

  state_t state_q;
  logic   in_wait;
  logic   rsp_hit;
  logic   expired;

  assign in_wait = (state_q == ST_FETCH_WAIT) || (state_q == ST_MEM_WAIT) ||
                   (state_q == ST_MDU_WAIT);

  always_comb begin
    rsp_hit = 1'b0;
    case (state_q)
      ST_FETCH_WAIT: rsp_hit = ifu_rsp_valid;
      ST_MEM_WAIT:   rsp_hit = lsu_rsp_valid;
      ST_MDU_WAIT:   rsp_hit = mdu_done;
      default:       rsp_hit = 1'b0;
    endcase
  end

  // Clearing outside the wait states means every wait starts from zero.
  npc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .en      (in_wait && !rsp_hit),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH_REQ;
      instr       <= NOP_INSTR;
      err         <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != ST_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      case (state_q)
        ST_FETCH_REQ: begin
          if (ifu_req_ready) state_q <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            instr   <= ifu_rsp_data;
            state_q <= ST_EXEC;
          end else if (expired) begin
            err     <= 1'b1;
            state_q <= ST_HALT;
          end
        end
        ST_EXEC: begin
          if (dec_ebreak) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
            state_q     <= ST_HALT;
          end else if (dec_load || dec_store) begin
            state_q <= ST_MEM_REQ;
          end else if (dec_muldiv) begin
            state_q <= ST_MDU_WAIT;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM_REQ: begin
          if (lsu_req_ready) state_q <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            state_q <= ST_WB;
          end else if (expired) begin
            err     <= 1'b1;
            state_q <= ST_HALT;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done) begin
            state_q <= ST_WB;
          end else if (expired) begin
            err     <= 1'b1;
            state_q <= ST_HALT;
          end
        end
        ST_WB: begin
          instret_cnt <= instret_cnt + CNT_W'(1);
          state_q     <= ST_FETCH_REQ;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Strobes decode the state register; rst masks them during the reset cycle.
  assign ifu_req_valid = !rst && (state_q == ST_FETCH_REQ);
  assign lsu_req_valid = !rst && (state_q == ST_MEM_REQ);
  assign mdu_start     = !rst && (state_q == ST_EXEC) && !dec_ebreak &&
                         !dec_load && !dec_store && dec_muldiv;
  assign pc_we         = !rst && (state_q == ST_WB);
  assign rf_we_gate    = !rst && (state_q == ST_WB);
  assign halt          = (state_q == ST_HALT);
  assign state         = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a cycle-stepped memory/MDU responder and
// a retirement scoreboard, plus a second instance built with TIMEOUT=8.
module tb_exec_sequencer;
  import npc_pkg::*;

  localparam int CNT_W = 64;
  localparam logic [31:0] ADDI1  = 32'h00100093;
  localparam logic [31:0] ADDI2  = 32'h00200113;
  localparam logic [31:0] ADDI3  = 32'h00300193;
  localparam logic [31:0] LD     = 32'h00003283;
  localparam logic [31:0] DIVW   = 32'h023140BB;
  localparam logic [31:0] EBREAK = 32'h00100073;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_data  = '0;
  logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0, mdu_done = 1'b0;

  logic             ifu_req_valid, lsu_req_valid, mdu_start, pc_we, rf_we_gate, halt, err;
  logic [31:0]      instr;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [2:0]       state;
  logic [3:0]       dec;

  logic             t_ifu_req_valid, t_lsu_req_valid, t_mdu_start, t_pc_we, t_rf_we_gate, t_halt, t_err;
  logic [31:0]      t_instr;
  logic [CNT_W-1:0] t_cycle_cnt, t_instret_cnt;
  logic [2:0]       t_state;
  logic [3:0]       t_dec;

  // Control-unit stand-in: {ebreak, muldiv, store, load}
  function automatic logic [3:0] decode(input logic [31:0] i);
    logic [3:0] d;
    d[0] = (i[6:0] == 7'b0000011);
    d[1] = (i[6:0] == 7'b0100011);
    d[2] = ((i[6:0] == 7'b0110011) || (i[6:0] == 7'b0111011)) && (i[31:25] == 7'b0000001);
    d[3] = (i == 32'h00100073);
    return d;
  endfunction

  assign dec   = decode(instr);
  assign t_dec = decode(t_instr);

  exec_sequencer #(.TIMEOUT(255), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .instr(instr),
    .dec_load(dec[0]), .dec_store(dec[1]), .dec_muldiv(dec[2]), .dec_ebreak(dec[3]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .pc_we(pc_we), .rf_we_gate(rf_we_gate),
    .halt(halt), .err(err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .state(state)
  );

  exec_sequencer #(.TIMEOUT(8), .CNT_W(CNT_W)) dut_t (
    .clk(clk), .rst(rst),
    .ifu_req_valid(t_ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .instr(t_instr),
    .dec_load(t_dec[0]), .dec_store(t_dec[1]), .dec_muldiv(t_dec[2]), .dec_ebreak(t_dec[3]),
    .lsu_req_valid(t_lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .mdu_start(t_mdu_start), .mdu_done(mdu_done), .pc_we(t_pc_we), .rf_we_gate(t_rf_we_gate),
    .halt(t_halt), .err(t_err), .cycle_cnt(t_cycle_cnt), .instret_cnt(t_instret_cnt), .state(t_state)
  );

  // responder configuration and state
  int cfg_ifu_rdy_dly, cfg_ifu_rsp_dly, cfg_ifu_never;
  int cfg_lsu_rdy_dly, cfg_lsu_rsp_dly, cfg_mdu_n;
  int ifu_stall, ifu_cd, lsu_stall, lsu_cd, mdu_cd;
  bit ifu_acc_prev, lsu_acc_prev;
  logic [31:0] cur_word;
  logic [31:0] prog_q[$];

  // scoreboard and event counters
  logic [31:0] exp_q[$];
  int pc_cyc[$];
  int cyc, n_pc, n_rf, n_mdu_start, mdu_start_cyc, n_lsu_acc, n_ifu_after_halt;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pc_at(input int k);
    return (k < pc_cyc.size()) ? pc_cyc[k] : -1;
  endfunction

  task automatic cfg_default();
    cfg_ifu_rdy_dly = 0; cfg_ifu_rsp_dly = 1; cfg_ifu_never = 0;
    cfg_lsu_rdy_dly = 0; cfg_lsu_rsp_dly = 1; cfg_mdu_n = 1;
    prog_q.delete();
  endtask

  task automatic monitor();
    if (pc_we) begin
      n_pc++;
      pc_cyc.push_back(cyc);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_mis++;
        $error("FAIL sb_underflow: pc_we at cycle %0d observed, none expected", cyc);
      end
      if (exp_q.size() > 0) chk("sb_instr", instr, exp_q.pop_front());
    end
    if (rf_we_gate) n_rf++;
    if (mdu_start) begin
      n_mdu_start++;
      mdu_start_cyc = cyc;
    end
    if (halt && ifu_req_valid) n_ifu_after_halt++;
  endtask

  // driver: inputs for the current cycle, from last edge's handshakes
  task automatic drive();
    if (ifu_acc_prev) ifu_cd = cfg_ifu_rsp_dly;
    ifu_rsp_valid = 1'b0;
    if (ifu_cd > 0) begin
      ifu_cd--;
      if (ifu_cd == 0 && cfg_ifu_never == 0) ifu_rsp_valid = 1'b1;
    end
    ifu_rsp_data = cur_word;

    if (lsu_acc_prev) lsu_cd = cfg_lsu_rsp_dly;
    lsu_rsp_valid = 1'b0;
    if (lsu_cd > 0) begin
      lsu_cd--;
      if (lsu_cd == 0) lsu_rsp_valid = 1'b1;
    end

    mdu_done = 1'b0;
    if (mdu_cd > 0) begin
      mdu_cd--;
      if (mdu_cd == 0) mdu_done = 1'b1;
    end
    if (mdu_start) mdu_cd = cfg_mdu_n;

    if (ifu_req_valid && prog_q.size() > 0) begin
      ifu_req_ready = (ifu_stall >= cfg_ifu_rdy_dly);
      ifu_stall++;
    end else begin
      ifu_req_ready = 1'b0;
      ifu_stall = 0;
    end
    ifu_acc_prev = ifu_req_valid && ifu_req_ready;
    if (ifu_acc_prev) begin
      cur_word = prog_q.pop_front();
      if (cur_word != EBREAK) exp_q.push_back(cur_word);
      ifu_stall = 0;
    end

    if (lsu_req_valid) begin
      lsu_req_ready = (lsu_stall >= cfg_lsu_rdy_dly);
      lsu_stall++;
    end else begin
      lsu_req_ready = 1'b0;
      lsu_stall = 0;
    end
    lsu_acc_prev = lsu_req_valid && lsu_req_ready;
    if (lsu_acc_prev) begin
      n_lsu_acc++;
      lsu_stall = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    drive();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Two reset edges; checks reset state while rst is still high, then leaves
  // the bench observing cycle 1 (first FETCH_REQ).
  task automatic do_reset();
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0; mdu_done = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state", state, ST_FETCH_REQ);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_halt_err", {halt, err}, 0);
    chk("rst_strobes", {ifu_req_valid, lsu_req_valid, mdu_start, pc_we, rf_we_gate}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifu_stall = 0; ifu_cd = 0; lsu_stall = 0; lsu_cd = 0; mdu_cd = 0;
    ifu_acc_prev = 1'b0; lsu_acc_prev = 1'b0; cur_word = '0;
    exp_q.delete(); pc_cyc.delete();
    n_pc = 0; n_rf = 0; n_mdu_start = 0; mdu_start_cyc = -1; n_lsu_acc = 0; n_ifu_after_halt = 0;
    #1;
    cyc = 1;
    monitor();
    drive();
  endtask

  initial begin
    // ALU stream
    cfg_default();
    prog_q = '{ADDI1, ADDI2, ADDI3};
    do_reset();
    run_to(13);
    chk("alu_pc_count", n_pc, 3);
    chk("alu_pc_cyc0", pc_at(0), 4);
    chk("alu_pc_cyc1", pc_at(1), 8);
    chk("alu_pc_cyc2", pc_at(2), 12);
    chk("alu_instret", instret_cnt, 3);
    chk("alu_cycle_cnt", cycle_cnt, 12);
    chk("alu_rf_gate", n_rf, 3);
    chk("alu_sb_drain", exp_q.size(), 0);

    // Load with request backpressure and a slow response
    cfg_default();
    cfg_lsu_rdy_dly = 2; cfg_lsu_rsp_dly = 3;
    prog_q = '{LD};
    do_reset();
    run_to(14);
    chk("ld_pc_count", n_pc, 1);
    chk("ld_pc_cyc", pc_at(0), 10);
    chk("ld_lsu_acc", n_lsu_acc, 1);
    chk("ld_instret", instret_cnt, 1);
    chk("ld_sb_drain", exp_q.size(), 0);

    // Divide with a 33-cycle MDU
    cfg_default();
    cfg_mdu_n = 33;
    prog_q = '{DIVW};
    do_reset();
    run_to(40);
    chk("div_start_count", n_mdu_start, 1);
    chk("div_start_cyc", mdu_start_cyc, 3);
    chk("div_pc_cyc", pc_at(0), 37);
    chk("div_rf_gate", n_rf, 1);
    chk("div_instret", instret_cnt, 1);
    chk("div_sb_drain", exp_q.size(), 0);

    // ebreak after one addi
    cfg_default();
    prog_q = '{ADDI1, EBREAK};
    do_reset();
    run_to(7);
    chk("ebk_exec_state", state, ST_EXEC);
    run_to(8);
    chk("ebk_state", state, ST_HALT);
    chk("ebk_halt", halt, 1);
    chk("ebk_err", err, 0);
    chk("ebk_instret", instret_cnt, 2);
    chk("ebk_cycle_cnt", cycle_cnt, 7);
    run_to(16);
    chk("ebk_cycle_frozen", cycle_cnt, 7);
    chk("ebk_no_fetch", n_ifu_after_halt, 0);
    chk("ebk_pc_count", n_pc, 1);
    chk("ebk_state_hold", state, ST_HALT);

    // Fetch timeout (TIMEOUT=8 instance): FETCH_WAIT entered in cycle 2
    cfg_default();
    cfg_ifu_never = 1;
    prog_q = '{ADDI1};
    do_reset();
    run_to(9);
    chk("to_state_c9", t_state, ST_FETCH_WAIT);
    chk("to_halt_c9", t_halt, 0);
    run_to(10);
    chk("to_state_c10", t_state, ST_HALT);
    chk("to_err", t_err, 1);
    chk("to_halt", t_halt, 1);
    run_to(15);
    chk("to_cycle_frozen", t_cycle_cnt, 9);
    chk("to_long_state", state, ST_FETCH_WAIT);
    chk("to_long_err", err, 0);

    // Response on the last allowed wait cycle wins over the timeout
    cfg_default();
    cfg_ifu_rsp_dly = 8;
    prog_q = '{ADDI1};
    do_reset();
    run_to(10);
    chk("late_state", t_state, ST_EXEC);
    chk("late_err", t_err, 0);
    chk("late_instr", t_instr, ADDI1);
    run_to(12);
    chk("late_instret", t_instret_cnt, 1);
    chk("late_halt", t_halt, 0);

    // Reset while in MEM_WAIT; the load response lands afterwards
    cfg_default();
    cfg_lsu_rsp_dly = 5;
    prog_q = '{LD};
    do_reset();
    run_to(6);
    chk("mrst_pre_state", state, ST_MEM_WAIT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_state", state, ST_FETCH_REQ);
    chk("mrst_instr", instr, 32'h00000013);
    chk("mrst_counters", {cycle_cnt, instret_cnt}, 0);
    chk("mrst_pc_we", pc_we, 0);
    run_to(14);
    chk("mrst_pc_count", n_pc, 0);
    chk("mrst_state_after", state, ST_FETCH_REQ);
    chk("mrst_instret_after", instret_cnt, 0);
    chk("mrst_cycle_after", cycle_cnt, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
